dmem_responder: RTL and testbench

- Data-memory responder for the pipeline's MEM-stage data port.
- Accepts one read or write request per access, stalls the core through BUSYWAIT for a fixed multi-cycle latency, and performs byte/half/word lane steering.
- Returns sign- or zero-extended load data.
- Sits at top level between cpu and the testbench or SoC; provides the behavioural data memory the core drives.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 181 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and dmem_responder.
// MISALIGN_ERR exists only when DMEM_MISALIGN_ERR_EN is defined.
interface dmem_if;
  logic [31:0] ADDR;
  logic [31:0] WRITE_DATA;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
`ifdef DMEM_MISALIGN_ERR_EN
  logic        MISALIGN_ERR;

  modport master (output ADDR, WRITE_DATA, READ, WRITE,
                  input  READ_DATA, BUSYWAIT, MISALIGN_ERR);
  modport slave  (input  ADDR, WRITE_DATA, READ, WRITE,
                  output READ_DATA, BUSYWAIT, MISALIGN_ERR);
`else
  modport master (output ADDR, WRITE_DATA, READ, WRITE,
                  input  READ_DATA, BUSYWAIT);
  modport slave  (input  ADDR, WRITE_DATA, READ, WRITE,
                  output READ_DATA, BUSYWAIT);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Behavioural data memory with fixed-latency BUSYWAIT stall and byte/half/word lanes.
// Optional DMEM_MISALIGN_ERR_EN adds misalignment detection and the MISALIGN_ERR output.
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic   CLK,
  input  logic   RST_N,
  dmem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] lanes;
    logic [3:0]  mask;
    logic [31:0] res;
    case (size)
      2'b00: begin lanes = {4{wdata[7:0]}};  mask = 4'b0001 << off; end
      2'b01: begin lanes = {2{wdata[15:0]}}; mask = off[1] ? 4'b1100 : 4'b0011; end
      2'b10: begin lanes = wdata;            mask = 4'b1111; end
      default: begin lanes = wdata;          mask = 4'b0000; end
    endcase
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? lanes[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

`ifdef DMEM_MISALIGN_ERR_EN
  function automatic logic is_misaligned(input logic       is_write,
                                         input logic [1:0] size,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
    logic half_acc;
    logic word_acc;
    half_acc = is_write ? (size == 2'b01) : (f3[1:0] == 2'b01);
    word_acc = is_write ? (size == 2'b10) : (f3 == 3'b010);
    return (half_acc & off[0]) | (word_acc & (off != 2'b00));
  endfunction
`endif

  logic [31:0]          mem_r [0:(2**ADDR_BITS)-1];
  state_t               state_r;
  logic [3:0]           cnt_r;
  logic [ADDR_BITS-1:0] idx_r;
  logic [1:0]           off_r;
  logic [31:0]          wdata_r;
  logic                 is_write_r;
  logic [1:0]           size_r;
  logic [2:0]           f3_r;
  logic [31:0]          rdata_r;
  logic                 req_s;
  logic                 commit_s;
  logic                 mem_we_s;
  logic                 busy_s;
  logic                 bad_s;
  logic                 unused_addr_s;

  assign req_s         = bus.READ[3] | bus.WRITE[2];
  assign commit_s      = (state_r == ACCESS) && (cnt_r == 4'd0);
  assign unused_addr_s = ^bus.ADDR[31:ADDR_BITS+2];

`ifdef DMEM_MISALIGN_ERR_EN
  logic mis_r;
  logic err_r;
  assign bad_s            = mis_r;
  assign bus.MISALIGN_ERR = err_r;
`else
  assign bad_s = 1'b0;
`endif

  assign mem_we_s      = commit_s & is_write_r & ~bad_s;
  assign bus.READ_DATA = rdata_r;
  assign bus.BUSYWAIT  = busy_s;

  // Stall is combinational so the core freezes in the very cycle it issues.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      IDLE:    busy_s = req_s;
      ACCESS:  busy_s = 1'b1;
      DONE:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[idx_r] <= store_merge(mem_r[idx_r], wdata_r, size_r, off_r);
    end
  end

  // Request FSM: latch in IDLE, count down in ACCESS, one-cycle DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      idx_r      <= '0;
      off_r      <= 2'd0;
      wdata_r    <= 32'd0;
      is_write_r <= 1'b0;
      size_r     <= 2'd0;
      f3_r       <= 3'd0;
      rdata_r    <= 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
      mis_r      <= 1'b0;
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            idx_r      <= bus.ADDR[ADDR_BITS+1:2];
            off_r      <= bus.ADDR[1:0];
            wdata_r    <= bus.WRITE_DATA;
            is_write_r <= bus.WRITE[2];
            size_r     <= bus.WRITE[1:0];
            f3_r       <= bus.READ[2:0];
            cnt_r      <= 4'(LATENCY - 1);
            state_r    <= ACCESS;
`ifdef DMEM_MISALIGN_ERR_EN
            mis_r      <= is_misaligned(bus.WRITE[2], bus.WRITE[1:0],
                                        bus.READ[2:0], bus.ADDR[1:0]);
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            if (bad_s) begin
              rdata_r <= 32'd0;
            end else if (!is_write_r) begin
              rdata_r <= load_extend(mem_r[idx_r], f3_r, off_r);
            end else begin
              rdata_r <= rdata_r;
            end
`ifdef DMEM_MISALIGN_ERR_EN
            err_r   <= mis_r;
`endif
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
`ifdef DMEM_MISALIGN_ERR_EN
          err_r   <= 1'b0;
`endif
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=4, ADDR_BITS=10).
// Covers lanes, extension, wrap, hold-off, back-to-back, reset abort and the optional misalign path.
module tb_dmem_responder;

  logic CLK;
  logic RST_N;
  int   n_cmp  = 0;
  int   n_fail = 0;

  dmem_if bus();

  dmem_responder #(.ADDR_BITS(10), .LATENCY(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete access; returns load data, stall count and misalign observations.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] wd, input bit scramble,
                        output logic [31:0] rdata, output int stall,
                        output logic err_done, output logic err_other);
    bus.READ = rd; bus.WRITE = wr; bus.ADDR = a; bus.WRITE_DATA = wd;
    stall = 0; err_done = 1'b0; err_other = 1'b0;
    #1;
    while (bus.BUSYWAIT === 1'b1 && stall < 40) begin
`ifdef DMEM_MISALIGN_ERR_EN
      err_other |= (bus.MISALIGN_ERR !== 1'b0);
`endif
      stall++;
      if (scramble && stall == 2) begin
        bus.ADDR = 32'h54; bus.WRITE_DATA = 32'hFFFF_FFFF; bus.WRITE = 3'b110; bus.READ = 4'b1000;
      end
      @(negedge CLK); #1;
    end
    rdata = bus.READ_DATA;
`ifdef DMEM_MISALIGN_ERR_EN
    err_done = bus.MISALIGN_ERR;
`endif
    bus.READ = 4'd0; bus.WRITE = 3'd0;
    @(negedge CLK); #1;
`ifdef DMEM_MISALIGN_ERR_EN
    err_other |= (bus.MISALIGN_ERR !== 1'b0);
`endif
  endtask

  task automatic test_reset;
    RST_N = 1'b0; bus.READ = 4'd0; bus.WRITE = 3'd0; bus.ADDR = 32'd0; bus.WRITE_DATA = 32'd0;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (bus.BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSYWAIT); end
    n_cmp++; if (bus.READ_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.READ_DATA); end
`ifdef DMEM_MISALIGN_ERR_EN
    n_cmp++; if (bus.MISALIGN_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.MISALIGN_ERR); end
`endif
    bus.READ = 4'b1010; #1;
    n_cmp++; if (bus.BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL reset_busy_req: got %b want 1", bus.BUSYWAIT); end
    bus.READ = 4'd0;
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK); #1;
  endtask

  task automatic test_word;
    logic [31:0] r; int st; logic e1, e2;
    access(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 1'b0, r, st, e1, e2);
    n_cmp++; if (st !== 5) begin n_fail++; $display("FAIL sw_stall: got %0d want 5", st); end
    access(4'b1010, 3'b000, 32'h10, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (st !== 5) begin n_fail++; $display("FAIL lw_stall: got %0d want 5", st); end
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_0x10: got %h want deadbeef", r); end
  endtask

  task automatic test_byte;
    logic [31:0] r; int st; logic e1, e2;
    access(4'b0000, 3'b100, 32'h13, 32'h0000_007F, 1'b0, r, st, e1, e2);
    access(4'b1000, 3'b000, 32'h13, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_0x13: got %h want 0000007f", r); end
    access(4'b1000, 3'b000, 32'h10, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'hFFFF_FFEF) begin n_fail++; $display("FAIL lb_0x10: got %h want ffffffef", r); end
    access(4'b1100, 3'b000, 32'h10, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h0000_00EF) begin n_fail++; $display("FAIL lbu_0x10: got %h want 000000ef", r); end
    access(4'b1001, 3'b000, 32'h12, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h0000_7FAD) begin n_fail++; $display("FAIL lh_0x12: got %h want 00007fad", r); end
    access(4'b1101, 3'b000, 32'h10, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_0x10: got %h want 0000beef", r); end
  endtask

  task automatic test_half;
    logic [31:0] r; int st; logic e1, e2;
    access(4'b0000, 3'b110, 32'h20, 32'h1122_3344, 1'b0, r, st, e1, e2);
    access(4'b0000, 3'b101, 32'h22, 32'hFFFF_8001, 1'b0, r, st, e1, e2);
    access(4'b1001, 3'b000, 32'h22, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_0x22: got %h want ffff8001", r); end
    access(4'b1101, 3'b000, 32'h22, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_0x22: got %h want 00008001", r); end
    access(4'b1010, 3'b000, 32'h20, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h8001_3344) begin n_fail++; $display("FAIL lw_0x20: got %h want 80013344", r); end
  endtask

  task automatic test_misc;
    logic [31:0] r; int st; logic e1, e2;
    // size 11 store must not touch memory
    access(4'b0000, 3'b111, 32'h10, 32'd0, 1'b0, r, st, e1, e2);
    access(4'b1010, 3'b000, 32'h10, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h7FAD_BEEF) begin n_fail++; $display("FAIL size11_nowrite: got %h want 7fadbeef", r); end
    access(4'b1010, 3'b000, 32'h1010, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h7FAD_BEEF) begin n_fail++; $display("FAIL addr_wrap: got %h want 7fadbeef", r); end
    access(4'b1011, 3'b000, 32'h10, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL funct3_unused: got %h want 0", r); end
    access(4'b1010, 3'b110, 32'h30, 32'h0BAD_F00D, 1'b0, r, st, e1, e2);
    access(4'b1010, 3'b000, 32'h30, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rw_both_writes: got %h want 0badf00d", r); end
    access(4'b0000, 3'b110, 32'h54, 32'h0102_0304, 1'b0, r, st, e1, e2);
    access(4'b0000, 3'b110, 32'h50, 32'h5555_5555, 1'b1, r, st, e1, e2);
    n_cmp++; if (st !== 5) begin n_fail++; $display("FAIL scramble_stall: got %0d want 5", st); end
    access(4'b1010, 3'b000, 32'h50, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h5555_5555) begin n_fail++; $display("FAIL latched_addr: got %h want 55555555", r); end
    access(4'b1010, 3'b000, 32'h54, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h0102_0304) begin n_fail++; $display("FAIL input_change_ignored: got %h want 01020304", r); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] pat;
    logic [31:0] r1, r2;
    bus.READ = 4'b1010; bus.WRITE = 3'd0; bus.ADDR = 32'h10; bus.WRITE_DATA = 32'd0;
    r1 = 32'd0; r2 = 32'd0;
    #1;
    for (int i = 0; i < 12; i++) begin
      pat[11-i] = bus.BUSYWAIT;
      if (i == 5)  begin r1 = bus.READ_DATA; bus.ADDR = 32'h20; end
      if (i == 11) begin r2 = bus.READ_DATA; bus.READ = 4'd0; end
      @(negedge CLK); #1;
    end
    n_cmp++; if (pat !== 12'b1111_1011_1110) begin n_fail++; $display("FAIL b2b_busy_pattern: got %b want 111110111110", pat); end
    n_cmp++; if (r1 !== 32'h7FAD_BEEF) begin n_fail++; $display("FAIL b2b_first: got %h want 7fadbeef", r1); end
    n_cmp++; if (r2 !== 32'h8001_3344) begin n_fail++; $display("FAIL b2b_second: got %h want 80013344", r2); end
    @(negedge CLK); #1;
    n_cmp++; if (bus.BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL b2b_no_repeat: got %b want 0", bus.BUSYWAIT); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] r; int st; logic e1, e2;
    access(4'b0000, 3'b110, 32'h40, 32'hCAFE_F00D, 1'b0, r, st, e1, e2);
    access(4'b1010, 3'b000, 32'h40, 32'd0, 1'b0, r, st, e1, e2);
    bus.READ = 4'd0; bus.WRITE = 3'b110; bus.ADDR = 32'h40; bus.WRITE_DATA = 32'h1234_5678;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0; bus.WRITE = 3'd0;
    #1;
    n_cmp++; if (bus.BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.BUSYWAIT); end
    n_cmp++; if (bus.READ_DATA !== 32'd0) begin n_fail++; $display("FAIL abort_rdata: got %h want 0", bus.READ_DATA); end
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK); #1;
    access(4'b1010, 3'b000, 32'h40, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL abort_no_commit: got %h want cafef00d", r); end
  endtask

  task automatic test_misalign;
    logic [31:0] r; int st; logic e1, e2;
`ifdef DMEM_MISALIGN_ERR_EN
    access(4'b0000, 3'b110, 32'h41, 32'hAAAA_AAAA, 1'b0, r, st, e1, e2);
    n_cmp++; if (st !== 5) begin n_fail++; $display("FAIL mis_stall: got %0d want 5", st); end
    n_cmp++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL mis_err_done: got %b want 1", e1); end
    n_cmp++; if (e2 !== 1'b0) begin n_fail++; $display("FAIL mis_err_width: got %b want 0", e2); end
    access(4'b1010, 3'b000, 32'h40, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mis_no_write: got %h want cafef00d", r); end
    n_cmp++; if (e1 !== 1'b0) begin n_fail++; $display("FAIL aligned_no_err: got %b want 0", e1); end
    access(4'b1001, 3'b000, 32'h21, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL mis_load_zero: got %h want 0", r); end
    n_cmp++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL mis_load_err: got %b want 1", e1); end
`else
    access(4'b0000, 3'b101, 32'h23, 32'h0000_ABCD, 1'b0, r, st, e1, e2);
    access(4'b1010, 3'b000, 32'h20, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'hABCD_3344) begin n_fail++; $display("FAIL half_truncate: got %h want abcd3344", r); end
    access(4'b0000, 3'b110, 32'h43, 32'h1357_9BDF, 1'b0, r, st, e1, e2);
    access(4'b1010, 3'b000, 32'h41, 32'd0, 1'b0, r, st, e1, e2);
    n_cmp++; if (r !== 32'h1357_9BDF) begin n_fail++; $display("FAIL word_truncate: got %h want 13579bdf", r); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misc();
    test_back_to_back();
    test_reset_abort();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
